// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC operand sequencer.
package mac_seq_pkg;

  localparam int unsigned UNUM_W               = 32;
  localparam logic [UNUM_W-1:0] UNUM_ZERO      = 32'h0;
  localparam int unsigned DEFAULT_LEN_W        = 16;
  localparam int unsigned DEFAULT_MAX_INFLIGHT = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/mac_credit_counter.sv
// Saturating up/down credit counter: inc and dec in the same cycle cancel,
// dec at zero and inc at the limit are ignored.
module mac_credit_counter #(
  parameter int unsigned W   = 2,
  parameter int unsigned MAX = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_full
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] r_count;

  // Credit usage: +1 per issued finish, -1 per returned finish, saturating.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != MAX_C)) begin
      r_count <= r_count + W'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count >= MAX_C);

endmodule

// File: rtl/mac_operand_sequencer.sv
// Transmitter side of the MAC operand interface: streams len-element dot
// products to the accumulator, flags the last element with mac_finish and
// limits outstanding dot products using returned mac_finish_out credits.
// Optional build macro: MAC_SEQ_ZERO_SKIP_EN (pairs containing a unum zero
// are consumed and counted but not driven with mac_valid).
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned LEN_W        = DEFAULT_LEN_W,
  parameter int unsigned MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [LEN_W-1:0]  num_dots,
  output logic              busy,
  output logic              done,
  output logic              err_zero,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [UNUM_W-1:0] op_a,
  input  logic [UNUM_W-1:0] op_b,
  output logic [UNUM_W-1:0] mac_unum1,
  output logic [UNUM_W-1:0] mac_unum2,
  output logic              mac_valid,
  output logic              mac_finish,
  output logic              mac_rst,
  input  logic              mac_finish_out,
  output logic [1:0]        inflight
);

  seq_state_t        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_num_dots;
  logic [LEN_W-1:0]  r_elem;
  logic [LEN_W-1:0]  r_dot;
  logic              r_busy;
  logic              r_done;
  logic              r_err_zero;
  logic              r_mac_valid;
  logic              r_mac_finish;
  logic              r_mac_rst;
  logic [UNUM_W-1:0] r_unum1;
  logic [UNUM_W-1:0] r_unum2;

  logic [1:0]        w_count;
  logic              w_full;
  logic              w_hs;
  logic              w_last_elem;
  logic              w_last_dot;
  logic              w_issue_fin;
  logic              w_drive_valid;

  assign op_ready    = (r_state == STREAM) && !w_full;
  assign w_hs        = op_valid && op_ready;
  assign w_last_elem = (r_elem == (r_len - LEN_W'(1)));
  assign w_last_dot  = (r_dot == (r_num_dots - LEN_W'(1)));
  assign w_issue_fin = w_hs && w_last_elem;

`ifdef MAC_SEQ_ZERO_SKIP_EN
  assign w_drive_valid = (op_a != UNUM_ZERO) && (op_b != UNUM_ZERO);
`else
  assign w_drive_valid = 1'b1;
`endif

  mac_credit_counter #(
    .W   (2),
    .MAX (MAX_INFLIGHT)
  ) u_credit (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_issue_fin),
    .i_dec   (mac_finish_out),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // Job sequencing FSM with registered accumulator-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_num_dots   <= '0;
      r_elem       <= '0;
      r_dot        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_zero   <= 1'b0;
      r_mac_valid  <= 1'b0;
      r_mac_finish <= 1'b0;
      r_mac_rst    <= 1'b0;
      r_unum1      <= '0;
      r_unum2      <= '0;
    end else begin
      r_done       <= 1'b0;
      r_err_zero   <= 1'b0;
      r_mac_valid  <= 1'b0;
      r_mac_finish <= 1'b0;
      r_mac_rst    <= 1'b0;
      // busy stays high through the done cycle; a start accepted in that
      // same cycle (state already IDLE) re-asserts it below.
      if (r_done) begin
        r_busy <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if ((len == '0) || (num_dots == '0)) begin
              r_err_zero <= 1'b1;
            end else begin
              r_len      <= len;
              r_num_dots <= num_dots;
              r_busy     <= 1'b1;
              r_mac_rst  <= 1'b1;
              r_state    <= CLEAR;
            end
          end
        end
        CLEAR: begin
          r_elem  <= '0;
          r_dot   <= '0;
          r_state <= STREAM;
        end
        STREAM: begin
          if (w_hs) begin
            r_unum1      <= op_a;
            r_unum2      <= op_b;
            r_mac_valid  <= w_drive_valid;
            r_mac_finish <= w_last_elem;
            if (w_last_elem) begin
              r_elem <= '0;
              r_dot  <= r_dot + LEN_W'(1);
              if (w_last_dot) begin
                r_state <= DRAIN;
              end
            end else begin
              r_elem <= r_elem + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (w_count == '0) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err_zero   = r_err_zero;
  assign mac_unum1  = r_unum1;
  assign mac_unum2  = r_unum2;
  assign mac_valid  = r_mac_valid;
  assign mac_finish = r_mac_finish;
  assign mac_rst    = r_mac_rst;
  assign inflight   = w_count;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer: a transaction-level model
// (accepted-pair count against len*num_dots, credit count) is compared with
// the DUT every cycle, plus literal per-test expectations.
module tb_mac_operand_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, op_valid;
  logic [15:0] len, num_dots;
  logic        fo_man, fo_auto, auto_ret, data_auto;
  logic [31:0] man_a, man_b, gen_a, gen_b;
  logic [31:0] op_a, op_b;
  logic        mac_finish_out;
  logic        busy, done, err_zero, op_ready;
  logic [31:0] mac_unum1, mac_unum2;
  logic        mac_valid, mac_finish, mac_rst;
  logic [1:0]  inflight;

  assign op_a           = data_auto ? gen_a : man_a;
  assign op_b           = data_auto ? gen_b : man_b;
  assign mac_finish_out = fo_man | fo_auto;

  mac_operand_sequencer #(.LEN_W(16), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .num_dots(num_dots),
    .busy(busy), .done(done), .err_zero(err_zero),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_unum1(mac_unum1), .mac_unum2(mac_unum2), .mac_valid(mac_valid),
    .mac_finish(mac_finish), .mac_rst(mac_rst),
    .mac_finish_out(mac_finish_out), .inflight(inflight)
  );

  // ---------------- behavioural model ----------------
  logic        m_active, m_clear, m_stream, m_drain;
  int unsigned m_acc, m_total, m_len, m_cred;
  logic        e_busy, e_done, e_err, e_rst, e_valid, e_fin;
  logic [31:0] e_u1, e_u2;
  logic        m_ready, m_hs, m_fin, m_last, m_skip;

  assign m_ready = m_stream && (m_cred < 2);
  assign m_hs    = m_ready && op_valid;
  assign m_fin   = m_hs && (m_len != 0) && (((m_acc + 1) % m_len) == 0);
  assign m_last  = m_hs && ((m_acc + 1) == m_total);
`ifdef MAC_SEQ_ZERO_SKIP_EN
  assign m_skip  = (op_a == 32'h0) || (op_b == 32'h0);
`else
  assign m_skip  = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_clear <= 0; m_stream <= 0; m_drain <= 0;
      m_acc <= 0; m_total <= 0; m_len <= 0; m_cred <= 0;
      e_busy <= 0; e_done <= 0; e_err <= 0; e_rst <= 0; e_valid <= 0; e_fin <= 0;
      e_u1 <= 0; e_u2 <= 0;
    end else begin
      e_done <= 0; e_err <= 0; e_rst <= 0; e_valid <= 0; e_fin <= 0;
      if (m_fin && !mac_finish_out && m_cred < 2) m_cred <= m_cred + 1;
      else if (mac_finish_out && !m_fin && m_cred > 0) m_cred <= m_cred - 1;
      if (m_hs) begin
        e_u1 <= op_a; e_u2 <= op_b; e_valid <= !m_skip; e_fin <= m_fin;
        m_acc <= m_acc + 1;
        if (m_last) begin m_stream <= 0; m_drain <= 1; end
      end
      if (m_clear) begin m_clear <= 0; m_stream <= 1; m_acc <= 0; end
      if (m_drain && m_cred == 0) begin m_drain <= 0; m_active <= 0; e_done <= 1; end
      if (e_done) e_busy <= 0;
      if (!m_active && start) begin
        if (len == 0 || num_dots == 0) e_err <= 1;
        else begin
          m_active <= 1; m_clear <= 1; e_rst <= 1; e_busy <= 1;
          m_len <= len; m_total <= len * num_dots; m_acc <= 0;
        end
      end
    end
  end

  // ---------------- responder / data generator ----------------
  int unsigned cyc;
  int unsigned due[$];
  initial begin
    cyc = 0; fo_auto = 0; gen_a = 32'h1000_0000; gen_b = 32'hA5A5_0000;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      gen_a = 32'h1000_0000 + cyc;
      gen_b = 32'hA5A5_0000 ^ cyc;
      fo_auto = 0;
      if (rst) due.delete();
      else if (due.size() > 0 && due[0] <= cyc) begin
        fo_auto = 1;
        void'(due.pop_front());
      end
      @(negedge clk);
      if (rst) due.delete();
      else if (auto_ret && mac_finish) due.push_back(cyc + 5);
    end
  end

  // ---------------- checking ----------------
  int n_total = 0, n_bad = 0;
  int vcount = 0, nfin = 0, nrst = 0, ndone = 0, nerr = 0;
  int fin_pos[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int fpos(input int i);
    return (i < fin_pos.size()) ? fin_pos[i] : -1;
  endfunction

  task automatic cycle_check();
    chk("op_ready", op_ready, m_ready);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err_zero", err_zero, e_err);
    chk("mac_rst", mac_rst, e_rst);
    chk("mac_valid", mac_valid, e_valid);
    chk("mac_finish", mac_finish, e_fin);
    chk("mac_unum1", mac_unum1, e_u1);
    chk("mac_unum2", mac_unum2, e_u2);
    chk("inflight", inflight, m_cred);
    if (mac_valid) begin
      vcount++;
      if (mac_finish) fin_pos.push_back(vcount);
    end
    if (mac_finish) nfin++;
    if (mac_rst) nrst++;
    if (done) ndone++;
    if (err_zero) nerr++;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] l, input logic [15:0] n);
    start = 1; len = l; num_dots = n;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && ndone == d0; i++) tick();
    chk("done_count", ndone - d0, 1);
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && !op_ready; i++) tick();
    chk("ready_seen", op_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int vb, fb, rb, db, eb, nb;

  initial begin
    rst = 1; start = 0; len = 0; num_dots = 0; op_valid = 0;
    fo_man = 0; auto_ret = 0; data_auto = 1; man_a = 0; man_b = 0;
    tick(); tick();
    chk("reset_ctrl", {busy, done, err_zero, op_ready, mac_valid, mac_finish, mac_rst, inflight}, 0);
    chk("reset_data", mac_unum1 | mac_unum2, 0);
    rst = 0;
    tick();

    // len=3, num_dots=2, returns 5 cycles after each finish
    vb = vcount; fb = fin_pos.size(); rb = nrst; db = ndone;
    auto_ret = 1; op_valid = 1;
    start_job(16'd3, 16'd2);
    wait_done(db, 200);
    op_valid = 0; auto_ret = 0;
    tick();
    chk("t1_rst_pulses", nrst - rb, 1);
    chk("t1_pairs", vcount - vb, 6);
    chk("t1_fin_count", fin_pos.size() - fb, 2);
    chk("t1_fin_pos0", fpos(fb) - vb, 3);
    chk("t1_fin_pos1", fpos(fb + 1) - vb, 6);
    chk("t1_busy_end", busy, 0);

    // len=1, num_dots=4, credits withheld
    vb = vcount; db = ndone; nb = nfin;
    op_valid = 1;
    start_job(16'd1, 16'd4);
    repeat (20) tick();
    chk("t2_pairs_stalled", vcount - vb, 2);
    chk("t2_ready_low", op_ready, 0);
    chk("t2_inflight_full", inflight, 2);
    fo_man = 1; tick(); fo_man = 0;
    repeat (3) tick();
    chk("t2_pairs_released", vcount - vb, 3);
    chk("t2_inflight_again", inflight, 2);
    repeat (3) begin
      fo_man = 1; tick(); fo_man = 0;
      repeat (3) tick();
    end
    wait_done(db, 20);
    op_valid = 0;
    tick();
    chk("t2_pairs_total", vcount - vb, 4);
    chk("t2_fin_total", nfin - nb, 4);

    // zero-field start
    eb = nerr; rb = nrst;
    start_job(16'd0, 16'd3);
    tick();
    chk("t3_err_len0", nerr - eb, 1);
    chk("t3_busy_len0", busy, 0);
    start_job(16'd5, 16'd0);
    tick();
    chk("t3_err_nd0", nerr - eb, 2);
    chk("t3_no_rst", nrst - rb, 0);

    // start while busy is ignored
    vb = vcount; fb = fin_pos.size(); rb = nrst; db = ndone;
    auto_ret = 1;
    start_job(16'd2, 16'd1);
    repeat (3) tick();
    start_job(16'd5, 16'd5);
    tick();
    chk("t3_busy_hold", busy, 1);
    op_valid = 1;
    wait_done(db, 50);
    op_valid = 0; auto_ret = 0;
    tick();
    chk("t3_pairs", vcount - vb, 2);
    chk("t3_fin_pos", fpos(fb) - vb, 2);
    chk("t3_fin_count", fin_pos.size() - fb, 1);
    chk("t3_rst_once", nrst - rb, 1);

    // simultaneous finish and return; spurious return at zero
    vb = vcount; db = ndone;
    start_job(16'd1, 16'd3);
    wait_ready(10);
    op_valid = 1; tick(); op_valid = 0;
    chk("t4_inflight_1", inflight, 1);
    op_valid = 1; fo_man = 1; tick(); op_valid = 0; fo_man = 0;
    chk("t4_same_cycle", inflight, 1);
    chk("t4_pairs", vcount - vb, 1);
    fo_man = 1; tick(); fo_man = 0;
    chk("t4_return", inflight, 0);
    fo_man = 1; tick(); fo_man = 0;
    chk("t4_spurious", inflight, 0);
    op_valid = 1; tick(); op_valid = 0;
    chk("t4_last_issue", inflight, 1);
    fo_man = 1; tick(); fo_man = 0;
    wait_done(db, 10);
    chk("t4_pairs_total", vcount - vb, 3);

    // reset mid-job, then a clean job
    vb = vcount;
    auto_ret = 1; op_valid = 1;
    start_job(16'd4, 16'd2);
    for (int i = 0; i < 50 && (vcount - vb) < 2; i++) tick();
    rst = 1;
    #1;
    chk("t5_rst_ctrl", {busy, done, err_zero, op_ready, mac_valid, mac_finish, mac_rst, inflight}, 0);
    chk("t5_rst_data", mac_unum1 | mac_unum2, 0);
    tick(); tick();
    rst = 0;
    vb = vcount; fb = fin_pos.size(); rb = nrst; db = ndone;
    start_job(16'd4, 16'd2);
    wait_done(db, 200);
    op_valid = 0; auto_ret = 0;
    tick();
    chk("t5_rst_pulse", nrst - rb, 1);
    chk("t5_pairs", vcount - vb, 8);
    chk("t5_fin_pos0", fpos(fb) - vb, 4);
    chk("t5_fin_pos1", fpos(fb + 1) - vb, 8);

    // zero operands, len=2
    vb = vcount; nb = nfin; db = ndone;
    data_auto = 0;
    start_job(16'd2, 16'd1);
    wait_ready(10);
    man_a = 32'h0; man_b = 32'h3F80_0000; op_valid = 1;
    tick();
    man_a = 32'h0; man_b = 32'h4000_0000;
    tick();
    op_valid = 0;
    tick();
    chk("t6_inflight", inflight, 1);
    chk("t6_fin", nfin - nb, 1);
`ifdef MAC_SEQ_ZERO_SKIP_EN
    chk("t6_valid_skip", vcount - vb, 0);
`else
    chk("t6_valid", vcount - vb, 2);
`endif
    chk("t6_unum2_last", mac_unum2, 32'h4000_0000);
    fo_man = 1; tick(); fo_man = 0;
    wait_done(db, 10);
    data_auto = 1;

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
